trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
Machine-mode trap sequencer for the pipeline CPU. It sits between the interrupt/exception sources, the pipeline control (stall/flush/redirect) and the CSR register file. It arbitrates pending interrupts against synchronous exceptions and mret. For each taken event it drains the pipeline, writes mepc/mcause/mstatus through the CSR write port in a fixed sequence, then redirects fetch to mtvec or mepc.

Parameters:
XLEN, 32, data/address width of PC and CSRs
CSR_MEPC, 12'h341, mepc address
CSR_MCAUSE, 12'h342, mcause address
CSR_MSTATUS, 12'h300, mstatus address

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
ext_irq_i / sft_irq_i / tmr_irq_i  in  1 each  raw interrupt pending levels
meie_i / msie_i / mtie_i  in  1 each  per-source enables from CSR file
glb_irq_i  in  1  mstatus.MIE
exc_req_i  in  1  synchronous exception from EX stage
exc_cause_i  in  4  exception code
exc_pc_i  in  XLEN  PC of faulting instruction
int_pc_i  in  XLEN  PC of oldest uncommitted instruction
mret_req_i  in  1  mret reached EX
pipe_idle_i  in  1  MEM/WB hold no valid instruction
mstatus_i / mtvec_i / mepc_i  in  XLEN each  current CSR values
stall_o  out  1  freeze fetch/decode
flush_o  out  1  kill IF/ID/EX contents
csr_wen_o  out  1  CSR write strobe
csr_addr_o  out  12  CSR write address
csr_wdata_o  out  XLEN  CSR write data
redirect_o  out  1  one-cycle fetch redirect
redirect_pc_o  out  XLEN  redirect target
busy_o  out  1  FSM not IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, captured cause/epc registers 0.
- Interrupt pending: (ext&meie) | (sft&msie) | (tmr&mtie), gated by glb_irq_i.
- IDLE arbitration at cycle T, priority exception > mret > ext > sft > tmr. Lower-priority requests are ignored that cycle.
- Capture at T:
  - cause: exceptions {0, 27'b0, exc_cause_i}; ext {1, ...11}; sft {1, ...3}; tmr {1, ...7}.
  - epc: exc_pc_i for exceptions, int_pc_i for interrupts.
- States:
  - IDLE: on trap -> DRAIN; on mret -> M_STAT.
  - DRAIN: stall_o=1, flush_o=1 for the first DRAIN cycle only. Stays until pipe_idle_i=1, then -> W_EPC.
  - W_EPC: write CSR_MEPC = epc -> W_CAUSE.
  - W_CAUSE: write CSR_MCAUSE = cause -> W_STAT.
  - W_STAT: write CSR_MSTATUS = mstatus_i with MPIE(7) <= MIE(3), MIE <= 0, MPP(12:11) <= 2'b11 -> REDIR.
  - M_STAT (mret): write mstatus with MIE <= MPIE, MPIE <= 1 -> REDIR; flush_o=1 in this cycle.
  - REDIR: redirect_o=1 for exactly one cycle -> IDLE.
- Trap target: mtvec_i[1:0]==01 and interrupt gives {mtvec_i[XLEN-1:2],2'b00} + (cause[3:0]<<2). Otherwise {mtvec_i[XLEN-1:2],2'b00}.
- mret target: mepc_i sampled in REDIR.
- stall_o=1 in every state except IDLE. busy_o mirrors it.
- csr_wen_o is high only in W_*/M_STAT states. csr_addr_o/csr_wdata_o are 0 when not writing.
- Minimum trap latency: request at T with pipe_idle_i=1 gives writes at T+2..T+4 and redirect at T+5. Minimum mret latency: redirect at T+2.
- While not IDLE, new requests are not sampled. Sources are level-held by the owner. Interrupts stay masked afterwards because MIE=0.
- Arithmetic: vector offset is XLEN wide with wrap-around modulo 2^XLEN; no overflow flag.
- Reset asserted in any state: next cycle IDLE, no further CSR write, no redirect.

Decomposition:
- Shared package (define.v): CSR addresses, mstatus bit indices (MIE, MPIE, MPP), cause codes (11/3/7), FSM state encodings.
- One sub-module, trap_arb: combinational priority encoder producing take_trap, take_mret, is_irq, cause[XLEN-1:0].
- The FSM and target computation stay in trap_ctrl.

Test Plan:
1. Exception: glb_irq=0, exc_req=1, cause=2, exc_pc=0x100, mtvec=0x800, pipe_idle=1 -> writes mepc=0x100, mcause=0x2, mstatus MIE=0/MPIE=old MIE; redirect to 0x800 at T+5.
2. Vectored irq: mtvec=0x801, tmr&mtie, glb=1, int_pc=0x204 -> mcause=0x80000007, mepc=0x204, redirect 0x81C.
3. Priority: ext, sft, tmr all enabled and pending together -> mcause=0x8000000B. The same case plus exc_req -> exception cause taken.
4. Drain: pipe_idle=0 for 3 cycles after request -> flush one cycle, stall held, first CSR write only after pipe_idle=1.
5. mret: mstatus MPIE=1/MIE=0, mepc=0x300 -> one mstatus write with MIE=1/MPIE=1, redirect 0x300 at T+2.
6. Reset mid-sequence: rst_n=0 during W_CAUSE -> next cycle all outputs 0, no mstatus write, no redirect.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses, mstatus
// bit positions, interrupt cause codes, FSM states and mstatus update helpers.
package trap_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [3:0] CAUSE_EXT = 4'd11;
  localparam logic [3:0] CAUSE_SFT = 4'd3;
  localparam logic [3:0] CAUSE_TMR = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_W_EPC,
    ST_W_CAUSE,
    ST_W_STAT,
    ST_M_STAT,
    ST_REDIR
  } state_e;

  function automatic logic [XLEN-1:0] make_cause(input logic irq, input logic [3:0] code);
    return {irq, {(XLEN-5){1'b0}}, code};
  endfunction

  // Trap entry stacks MIE into MPIE, masks interrupts and records M-mode as the previous privilege.
  function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r = m;
    r[MSTATUS_MPIE] = m[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r = m;
    r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Signal bundle between the trap sequencer and the rest of the CPU
// (interrupt sources, pipeline control, CSR file).
interface trap_ctrl_if;
  import trap_ctrl_pkg::*;

  logic            ext_irq_i;
  logic            sft_irq_i;
  logic            tmr_irq_i;
  logic            meie_i;
  logic            msie_i;
  logic            mtie_i;
  logic            glb_irq_i;
  logic            exc_req_i;
  logic [3:0]      exc_cause_i;
  logic [XLEN-1:0] exc_pc_i;
  logic [XLEN-1:0] int_pc_i;
  logic            mret_req_i;
  logic            pipe_idle_i;
  logic [XLEN-1:0] mstatus_i;
  logic [XLEN-1:0] mtvec_i;
  logic [XLEN-1:0] mepc_i;

  logic            stall_o;
  logic            flush_o;
  logic            csr_wen_o;
  logic [11:0]     csr_addr_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic            redirect_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            busy_o;

  modport master (
    output ext_irq_i, sft_irq_i, tmr_irq_i, meie_i, msie_i, mtie_i, glb_irq_i,
    output exc_req_i, exc_cause_i, exc_pc_i, int_pc_i, mret_req_i, pipe_idle_i,
    output mstatus_i, mtvec_i, mepc_i,
    input  stall_o, flush_o, csr_wen_o, csr_addr_o, csr_wdata_o,
    input  redirect_o, redirect_pc_o, busy_o
  );

  modport slave (
    input  ext_irq_i, sft_irq_i, tmr_irq_i, meie_i, msie_i, mtie_i, glb_irq_i,
    input  exc_req_i, exc_cause_i, exc_pc_i, int_pc_i, mret_req_i, pipe_idle_i,
    input  mstatus_i, mtvec_i, mepc_i,
    output stall_o, flush_o, csr_wen_o, csr_addr_o, csr_wdata_o,
    output redirect_o, redirect_pc_o, busy_o
  );

endinterface

// File: rtl/trap_ctrl_arb.sv
// Combinational priority encoder: exception > mret > external > software > timer.
// Produces the event to take this cycle and the mcause value it would record.
module trap_arb
  import trap_ctrl_pkg::*;
(
  input  logic            ext_irq_i,
  input  logic            sft_irq_i,
  input  logic            tmr_irq_i,
  input  logic            meie_i,
  input  logic            msie_i,
  input  logic            mtie_i,
  input  logic            glb_irq_i,
  input  logic            exc_req_i,
  input  logic [3:0]      exc_cause_i,
  input  logic            mret_req_i,
  output logic            take_trap_o,
  output logic            take_mret_o,
  output logic            is_irq_o,
  output logic [XLEN-1:0] cause_o
);

  logic ext_pend;
  logic sft_pend;
  logic tmr_pend;

  assign ext_pend = ext_irq_i & meie_i & glb_irq_i;
  assign sft_pend = sft_irq_i & msie_i & glb_irq_i;
  assign tmr_pend = tmr_irq_i & mtie_i & glb_irq_i;

  always_comb begin
    take_trap_o = 1'b0;
    take_mret_o = 1'b0;
    is_irq_o    = 1'b0;
    cause_o     = '0;
    if (exc_req_i) begin
      take_trap_o = 1'b1;
      cause_o     = make_cause(1'b0, exc_cause_i);
    end else if (mret_req_i) begin
      take_mret_o = 1'b1;
    end else if (ext_pend) begin
      take_trap_o = 1'b1;
      is_irq_o    = 1'b1;
      cause_o     = make_cause(1'b1, CAUSE_EXT);
    end else if (sft_pend) begin
      take_trap_o = 1'b1;
      is_irq_o    = 1'b1;
      cause_o     = make_cause(1'b1, CAUSE_SFT);
    end else if (tmr_pend) begin
      take_trap_o = 1'b1;
      is_irq_o    = 1'b1;
      cause_o     = make_cause(1'b1, CAUSE_TMR);
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: drains the pipeline, writes mepc/mcause/mstatus in
// order and redirects fetch to the trap vector, or handles mret back to mepc.
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  trap_ctrl_if.slave bus
);

  logic            take_trap;
  logic            take_mret;
  logic            arb_is_irq;
  logic [XLEN-1:0] arb_cause;

  trap_arb u_arb (
    .ext_irq_i   (bus.ext_irq_i),
    .sft_irq_i   (bus.sft_irq_i),
    .tmr_irq_i   (bus.tmr_irq_i),
    .meie_i      (bus.meie_i),
    .msie_i      (bus.msie_i),
    .mtie_i      (bus.mtie_i),
    .glb_irq_i   (bus.glb_irq_i),
    .exc_req_i   (bus.exc_req_i),
    .exc_cause_i (bus.exc_cause_i),
    .mret_req_i  (bus.mret_req_i),
    .take_trap_o (take_trap),
    .take_mret_o (take_mret),
    .is_irq_o    (arb_is_irq),
    .cause_o     (arb_cause)
  );

  state_e          state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            is_irq_q, is_irq_d;
  logic            is_mret_q, is_mret_d;
  logic            stall_q, stall_d;
  logic            flush_q, flush_d;
  logic            csr_wen_q, csr_wen_d;
  logic [11:0]     csr_addr_q, csr_addr_d;
  logic            redirect_q, redirect_d;

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    is_irq_d  = is_irq_q;
    is_mret_d = is_mret_q;
    unique case (state_q)
      ST_IDLE: begin
        if (take_trap) begin
          state_d   = ST_DRAIN;
          cause_d   = arb_cause;
          epc_d     = arb_is_irq ? bus.int_pc_i : bus.exc_pc_i;
          is_irq_d  = arb_is_irq;
          is_mret_d = 1'b0;
        end else if (take_mret) begin
          state_d   = ST_M_STAT;
          is_mret_d = 1'b1;
        end
      end
      ST_DRAIN:   if (bus.pipe_idle_i) state_d = ST_W_EPC;
      ST_W_EPC:   state_d = ST_W_CAUSE;
      ST_W_CAUSE: state_d = ST_W_STAT;
      ST_W_STAT:  state_d = ST_REDIR;
      ST_M_STAT:  state_d = ST_REDIR;
      ST_REDIR:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Control outputs are registered, so they are decoded from the state being entered.
    stall_d    = (state_d != ST_IDLE);
    flush_d    = ((state_d == ST_DRAIN) && (state_q == ST_IDLE)) || (state_d == ST_M_STAT);
    redirect_d = (state_d == ST_REDIR);
    csr_wen_d  = 1'b0;
    csr_addr_d = '0;
    unique case (state_d)
      ST_W_EPC:   begin csr_wen_d = 1'b1; csr_addr_d = CSR_MEPC;    end
      ST_W_CAUSE: begin csr_wen_d = 1'b1; csr_addr_d = CSR_MCAUSE;  end
      ST_W_STAT,
      ST_M_STAT:  begin csr_wen_d = 1'b1; csr_addr_d = CSR_MSTATUS; end
      default:    begin csr_wen_d = 1'b0; csr_addr_d = '0;          end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cause_q    <= '0;
      epc_q      <= '0;
      is_irq_q   <= 1'b0;
      is_mret_q  <= 1'b0;
      stall_q    <= 1'b0;
      flush_q    <= 1'b0;
      csr_wen_q  <= 1'b0;
      csr_addr_q <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      is_irq_q   <= is_irq_d;
      is_mret_q  <= is_mret_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
      csr_wen_q  <= csr_wen_d;
      csr_addr_q <= csr_addr_d;
      redirect_q <= redirect_d;
    end
  end

  // Data paths read live CSR values in the cycle they are used; they hold zero otherwise.
  logic [XLEN-1:0] vec_base;
  logic [XLEN-1:0] vec_off;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] redirect_pc;

  assign vec_base    = {bus.mtvec_i[XLEN-1:2], 2'b00};
  assign vec_off     = {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00};
  assign trap_target = ((bus.mtvec_i[1:0] == 2'b01) && is_irq_q) ? vec_base + vec_off : vec_base;

  always_comb begin
    csr_wdata   = '0;
    redirect_pc = '0;
    unique case (state_q)
      ST_W_EPC:   csr_wdata = epc_q;
      ST_W_CAUSE: csr_wdata = cause_q;
      ST_W_STAT:  csr_wdata = mstatus_on_trap(bus.mstatus_i);
      ST_M_STAT:  csr_wdata = mstatus_on_mret(bus.mstatus_i);
      ST_REDIR:   redirect_pc = is_mret_q ? bus.mepc_i : trap_target;
      default:    csr_wdata = '0;
    endcase
  end

  assign bus.stall_o       = stall_q;
  assign bus.busy_o        = stall_q;
  assign bus.flush_o       = flush_q;
  assign bus.csr_wen_o     = csr_wen_q;
  assign bus.csr_addr_o    = csr_addr_q;
  assign bus.csr_wdata_o   = csr_wdata;
  assign bus.redirect_o    = redirect_q;
  assign bus.redirect_pc_o = redirect_pc;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed table of trap/mret events, a reset
// abort sequence and randomized events checked against a behavioural model.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  trap_ctrl_if bus ();

  trap_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        wen;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        redir;
    logic [31:0] pc;
    logic        busy;
  } obs_t;

  typedef struct {
    logic        ext, sft, tmr, meie, msie, mtie, glb;
    logic        exc_req;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc, int_pc;
    logic        mret;
    logic [31:0] mstatus, mtvec, mepc;
    int          nd;
  } stim_t;

  // kind: 0 = nothing taken, 1 = trap, 2 = mret
  typedef struct {
    int          kind;
    logic [31:0] epc, cause, mstat, target;
  } exp_t;

  typedef struct {
    string name;
    stim_t s;
    exp_t  e;
  } vec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl[$];

  function automatic stim_t idle_stim();
    stim_t s;
    s.ext = 0; s.sft = 0; s.tmr = 0; s.meie = 0; s.msie = 0; s.mtie = 0; s.glb = 0;
    s.exc_req = 0; s.exc_cause = 0; s.exc_pc = 0; s.int_pc = 0; s.mret = 0;
    s.mstatus = 0; s.mtvec = 0; s.mepc = 0; s.nd = 0;
    return s;
  endfunction

  function automatic exp_t mk_exp(int kind, logic [31:0] epc, logic [31:0] cause,
                                  logic [31:0] mstat, logic [31:0] target);
    exp_t e;
    e.kind = kind; e.epc = epc; e.cause = cause; e.mstat = mstat; e.target = target;
    return e;
  endfunction

  // Reference model: architectural outcome of an event, derived from the trap rules.
  function automatic exp_t ref_model(stim_t s);
    exp_t        e;
    logic [31:0] base, mie, mpie;
    logic        irq;
    e = mk_exp(0, 0, 0, 0, 0);
    irq = 1'b0;
    if (s.exc_req) begin
      e.kind = 1; e.cause = 32'(s.exc_cause); e.epc = s.exc_pc;
    end else if (s.mret) begin
      e.kind = 2;
    end else if (s.glb && ((s.ext && s.meie) || (s.sft && s.msie) || (s.tmr && s.mtie))) begin
      e.kind = 1; e.epc = s.int_pc; irq = 1'b1;
      if (s.ext && s.meie)      e.cause = 32'h8000_0000 + 11;
      else if (s.sft && s.msie) e.cause = 32'h8000_0000 + 3;
      else                      e.cause = 32'h8000_0000 + 7;
    end
    mie  = (s.mstatus >> 3) & 1;
    mpie = (s.mstatus >> 7) & 1;
    if (e.kind == 1) begin
      e.mstat = (s.mstatus & ~32'h0000_1888) | (mie << 7) | (32'd3 << 11);
      base = s.mtvec - (s.mtvec % 4);
      if (irq && (s.mtvec % 4 == 1)) e.target = base + 4 * (e.cause % 16);
      else                           e.target = base;
    end else if (e.kind == 2) begin
      e.mstat  = (s.mstatus & ~32'h0000_0088) | (mpie << 3) | (32'd1 << 7);
      e.target = s.mepc;
    end
    return e;
  endfunction

  task automatic driveStim(stim_t s);
    bus.ext_irq_i = s.ext;  bus.sft_irq_i = s.sft;  bus.tmr_irq_i = s.tmr;
    bus.meie_i    = s.meie; bus.msie_i    = s.msie; bus.mtie_i    = s.mtie;
    bus.glb_irq_i = s.glb;  bus.exc_req_i = s.exc_req; bus.exc_cause_i = s.exc_cause;
    bus.exc_pc_i  = s.exc_pc; bus.int_pc_i = s.int_pc; bus.mret_req_i = s.mret;
    bus.mstatus_i = s.mstatus; bus.mtvec_i = s.mtvec; bus.mepc_i = s.mepc;
    bus.pipe_idle_i = (s.nd == 0);
  endtask

  task automatic clearReq();
    bus.exc_req_i = 0; bus.mret_req_i = 0;
    bus.ext_irq_i = 0; bus.sft_irq_i = 0; bus.tmr_irq_i = 0;
  endtask

  task automatic checkOutput(string name, obs_t exp);
    obs_t act;
    act = {bus.stall_o, bus.flush_o, bus.csr_wen_o, bus.csr_addr_o, bus.csr_wdata_o,
           bus.redirect_o, bus.redirect_pc_o, bus.busy_o};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Expected cycle-by-cycle outputs starting at the cycle after the request.
  task automatic buildTrace(exp_t e, int nd, output obs_t q[$]);
    obs_t o;
    q = {};
    if (e.kind == 1) begin
      for (int k = 0; k <= nd; k++) begin
        o = '0; o.stall = 1; o.busy = 1; o.flush = (k == 0); q.push_back(o);
      end
      o = '0; o.stall = 1; o.busy = 1; o.wen = 1;
      o.addr = 12'h341; o.wdata = e.epc;   q.push_back(o);
      o.addr = 12'h342; o.wdata = e.cause; q.push_back(o);
      o.addr = 12'h300; o.wdata = e.mstat; q.push_back(o);
    end else if (e.kind == 2) begin
      o = '0; o.stall = 1; o.busy = 1; o.flush = 1; o.wen = 1;
      o.addr = 12'h300; o.wdata = e.mstat; q.push_back(o);
    end
    if (e.kind != 0) begin
      o = '0; o.stall = 1; o.busy = 1; o.redir = 1; o.pc = e.target; q.push_back(o);
    end
    o = '0; q.push_back(o);
    if (e.kind == 0) q.push_back(o);
  endtask

  task automatic applyStimulus(string name, stim_t s, exp_t e);
    obs_t q[$];
    buildTrace(e, s.nd, q);
    @(negedge clk);
    driveStim(s);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s c%0d", name, i + 1), q[i]);
      clearReq();
      bus.pipe_idle_i = (i >= s.nd);
    end
  endtask

  initial begin
    stim_t s;
    exp_t  e;
    obs_t  q[$];
    obs_t  zero;
    zero = '0;

    // Reset while a request is presented must keep everything quiet.
    rst_n = 1'b0;
    s = idle_stim(); s.exc_req = 1; s.mtvec = 32'h800;
    driveStim(s);
    repeat (2) @(negedge clk);
    checkOutput("reset_hold", zero);
    clearReq();
    @(negedge clk);
    checkOutput("reset_idle", zero);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("after_reset", zero);

    s = idle_stim(); s.exc_req = 1; s.exc_cause = 2; s.exc_pc = 32'h100;
    s.mtvec = 32'h800; s.mstatus = 32'h8;
    tbl.push_back('{"exc_basic", s, mk_exp(1, 32'h100, 32'h2, 32'h1880, 32'h800)});

    s = idle_stim(); s.tmr = 1; s.mtie = 1; s.glb = 1; s.int_pc = 32'h204;
    s.mtvec = 32'h801; s.mstatus = 32'h8;
    tbl.push_back('{"vec_tmr", s, mk_exp(1, 32'h204, 32'h8000_0007, 32'h1880, 32'h81C)});

    s = idle_stim(); s.ext = 1; s.sft = 1; s.tmr = 1; s.meie = 1; s.msie = 1; s.mtie = 1;
    s.glb = 1; s.int_pc = 32'h40; s.mtvec = 32'h801; s.mstatus = 32'h8;
    tbl.push_back('{"prio_ext", s, mk_exp(1, 32'h40, 32'h8000_000B, 32'h1880, 32'h82C)});

    s.exc_req = 1; s.exc_cause = 5; s.exc_pc = 32'h500;
    tbl.push_back('{"prio_exc", s, mk_exp(1, 32'h500, 32'h5, 32'h1880, 32'h800)});

    s = idle_stim(); s.exc_req = 1; s.exc_cause = 4; s.exc_pc = 32'h120;
    s.mtvec = 32'h1000; s.nd = 3;
    tbl.push_back('{"drain3", s, mk_exp(1, 32'h120, 32'h4, 32'h1800, 32'h1000)});

    s = idle_stim(); s.mret = 1; s.mstatus = 32'h80; s.mepc = 32'h300;
    tbl.push_back('{"mret", s, mk_exp(2, 0, 0, 32'h88, 32'h300)});

    s = idle_stim(); s.sft = 1; s.msie = 1; s.glb = 1; s.int_pc = 32'h44;
    s.mtvec = 32'h2001; s.mstatus = 32'h8;
    tbl.push_back('{"vec_sft", s, mk_exp(1, 32'h44, 32'h8000_0003, 32'h1880, 32'h200C)});

    s = idle_stim(); s.ext = 1; s.sft = 1; s.tmr = 1; s.meie = 1; s.msie = 1; s.mtie = 1;
    s.mtvec = 32'h801;
    tbl.push_back('{"masked_glb", s, mk_exp(0, 0, 0, 0, 0)});

    s = idle_stim(); s.exc_req = 1; s.exc_cause = 3; s.exc_pc = 32'h60; s.mret = 1;
    s.mtvec = 32'h400; s.mstatus = 32'h1808;
    tbl.push_back('{"exc_over_mret", s, mk_exp(1, 32'h60, 32'h3, 32'h1880, 32'h400)});

    s = idle_stim(); s.mret = 1; s.tmr = 1; s.mtie = 1; s.glb = 1;
    s.mstatus = 32'h88; s.mepc = 32'h1234; s.mtvec = 32'h801;
    tbl.push_back('{"mret_over_irq", s, mk_exp(2, 0, 0, 32'h88, 32'h1234)});

    s = idle_stim(); s.ext = 1; s.meie = 1; s.glb = 1; s.int_pc = 32'h8;
    s.mtvec = 32'hFFFF_FFF1;
    tbl.push_back('{"vec_wrap", s, mk_exp(1, 32'h8, 32'h8000_000B, 32'h1800, 32'h1C)});

    s = idle_stim(); s.tmr = 1; s.mtie = 1; s.glb = 1; s.int_pc = 32'h10;
    s.mtvec = 32'h903; s.mstatus = 32'h8;
    tbl.push_back('{"mode3_direct", s, mk_exp(1, 32'h10, 32'h8000_0007, 32'h1880, 32'h900)});

    foreach (tbl[i]) applyStimulus(tbl[i].name, tbl[i].s, tbl[i].e);

    // Reset landing in W_CAUSE: the mstatus write and redirect must never appear.
    s = idle_stim(); s.exc_req = 1; s.exc_cause = 6; s.exc_pc = 32'h700;
    s.mtvec = 32'h800; s.mstatus = 32'h8;
    buildTrace(ref_model(s), 0, q);
    @(negedge clk);
    driveStim(s);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_mid c%0d", i + 1), q[i]);
      clearReq();
    end
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid abort", zero);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_mid quiet%0d", i), zero);
    end

    for (int n = 0; n < 40; n++) begin
      s = idle_stim();
      s.exc_req   = ($urandom_range(0, 3) == 0);
      s.mret      = ($urandom_range(0, 3) == 0);
      s.ext       = $urandom_range(0, 1);
      s.sft       = $urandom_range(0, 1);
      s.tmr       = $urandom_range(0, 1);
      s.meie      = $urandom_range(0, 1);
      s.msie      = $urandom_range(0, 1);
      s.mtie      = $urandom_range(0, 1);
      s.glb       = ($urandom_range(0, 3) != 0);
      s.exc_cause = 4'($urandom);
      s.exc_pc    = $urandom;
      s.int_pc    = $urandom;
      s.mstatus   = $urandom;
      s.mtvec     = $urandom;
      s.mepc      = $urandom;
      s.nd        = $urandom_range(0, 3);
      applyStimulus($sformatf("rand%0d", n), s, ref_model(s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
